// File: rtl/mult_div_unit.sv
// Purpose: sequential signed 32x32 multiply (HI:LO = a*b) and divide (LO = quotient, HI = remainder).
// Latency: DATA_W+1 cycles from accepted start to the done pulse; divide-by-zero finishes in 1 cycle.
// Backpressure: none; starts arriving while busy are dropped, never queued. Results hold until the next op.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-low reset
//   mult_start, div_start  start requests, sampled only in IDLE (multiply wins if both are high)
//   a_in, b_in             operands (multiplicand/dividend, multiplier/divisor), captured at accepted start
//   hi_out, lo_out         product high/low halves, or remainder/quotient
//   mult_done, div_done    one-cycle result-valid pulses
//   div_by_zero            high alongside div_done when the divisor was zero
//   busy                   high from the first RUN cycle through the DONE cycle
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mult_start,
    input  logic              div_start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              mult_done,
    output logic              div_done,
    output logic              div_by_zero,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_MUL = 2'd1,
        RUN_DIV = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient bits}.
    logic [2*DATA_W-1:0] acc;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [DATA_W-1:0]   op_m;
    logic                neg_q;   // negate product / quotient at the end
    logic                neg_r;   // negate remainder at the end (dividend sign)

    // Unsigned magnitude; the most negative value maps to itself, which is
    // still correct when read as an unsigned 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole accumulator right
    // with the carry falling into the top bit.
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;

    // One restoring-division step: shift {rem,quo} left, trial-subtract the
    // divisor from the widened remainder, keep the difference if it did not
    // borrow, and shift in the matching quotient bit.
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_trial;
    logic [2*DATA_W-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, op_m} : {(DATA_W+1){1'b0}});
        mul_next  = {mul_sum, acc[DATA_W-1:1]};

        div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_trial = div_shift - {1'b0, op_m};
        div_next  = div_trial[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                      : {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            op_m        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            mult_done   <= 1'b0;
            div_done    <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Done flags are pulses: only the transition into DONE raises them.
            mult_done   <= 1'b0;
            div_done    <= 1'b0;
            div_by_zero <= 1'b0;

            case (state)
                IDLE: begin
                    if (mult_start) begin
                        state <= RUN_MUL;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        acc   <= {{DATA_W{1'b0}}, mag(b_in)};
                        op_m  <= mag(a_in);
                        neg_q <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
                        neg_r <= 1'b0;
                    end else if (div_start) begin
                        busy <= 1'b1;
                        if (b_in == '0) begin
                            // No iterations: report immediately with fixed results.
                            state       <= DONE;
                            div_done    <= 1'b1;
                            div_by_zero <= 1'b1;
                            hi_out      <= a_in;
                            lo_out      <= '1;
                        end else begin
                            state <= RUN_DIV;
                            cnt   <= '0;
                            acc   <= {{DATA_W{1'b0}}, mag(a_in)};
                            op_m  <= mag(b_in);
                            neg_q <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
                            neg_r <= a_in[DATA_W-1];
                        end
                    end
                end

                RUN_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state     <= DONE;
                        mult_done <= 1'b1;
                        {hi_out, lo_out} <= neg_q ? -mul_next : mul_next;
                    end
                end

                RUN_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state    <= DONE;
                        div_done <= 1'b1;
                        lo_out   <= neg_q ? -div_next[DATA_W-1:0] : div_next[DATA_W-1:0];
                        hi_out   <= neg_r ? -div_next[2*DATA_W-1:DATA_W] : div_next[2*DATA_W-1:DATA_W];
                    end
                end

                DONE: begin
                    // Starts seen here are deliberately ignored.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose: directed self-checking bench for mult_div_unit (timing, results, arbitration, reset abort).
// Latency: expects done 33 cycles after an accepted start, 1 cycle for divide-by-zero.
// Backpressure: none; the bench drives starts at will and checks that busy-time starts are dropped.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] a_in = 32'h0;
    logic [31:0] b_in = 32'h0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        mult_done;
    logic        div_done;
    logic        div_by_zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .a_in        (a_in),
        .b_in        (b_in),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .mult_done   (mult_done),
        .div_done    (div_done),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start in the current cycle (cycle 0), then return sampling cycle 1.
    // Operand inputs are scrambled afterwards so late sampling would show up.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        mult_start = m;
        div_start  = d;
        a_in       = a;
        b_in       = b;
        step();
        mult_start = 1'b0;
        div_start  = 1'b0;
        a_in       = 32'hDEAD_BEEF;
        b_in       = 32'h0000_0000;
    endtask

    // Wait (bounded) for a done pulse; cyc is the cycle number it appeared in, -1 on timeout.
    task automatic wait_done(output int cyc, output logic sm, output logic sd, output logic sz);
        cyc = -1;
        sm  = 1'b0;
        sd  = 1'b0;
        sz  = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (mult_done || div_done) begin
                cyc = i;
                sm  = mult_done;
                sd  = div_done;
                sz  = div_by_zero;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        n_checks++;
        if ({hi_out, lo_out} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h_%h want 0", hi_out, lo_out);
        end
        n_checks++;
        if ({mult_done, div_done, div_by_zero, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got md=%b dd=%b dz=%b busy=%b want all 0",
                     mult_done, div_done, div_by_zero, busy);
        end
    endtask

    // 7 * -3 with cycle-by-cycle timing of done/busy and output hold during RUN.
    task automatic test_mult_timing();
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        for (int c = 1; c <= 33; c++) begin
            n_checks++;
            if (mult_done !== (c == 33) || busy !== 1'b1 || div_done !== 1'b0) begin
                n_fail++;
                $display("FAIL t1_timing cycle %0d: got md=%b dd=%b busy=%b want md=%b dd=0 busy=1",
                         c, mult_done, div_done, busy, (c == 33));
            end
            if (c < 33) begin
                n_checks++;
                if ({hi_out, lo_out} !== 64'h0) begin
                    n_fail++;
                    $display("FAIL t1_hold cycle %0d: got %h_%h want 0", c, hi_out, lo_out);
                end
                step();
            end
        end
        n_checks++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL t1_result: got hi=%h lo=%h want hi=ffffffff lo=ffffffeb", hi_out, lo_out);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || mult_done !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_idle: got busy=%b md=%b want 0 0", busy, mult_done);
        end
    endtask

    task automatic test_mult_corners();
        int   cyc;
        logic sm, sd, sz;
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(cyc, sm, sd, sz);
        n_checks++;
        if (cyc != 33 || sm !== 1'b1 || sd !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_min_done: got cycle=%0d md=%b dd=%b want 33 1 0", cyc, sm, sd);
        end
        n_checks++;
        if (hi_out !== 32'h4000_0000 || lo_out !== 32'h0) begin
            n_fail++;
            $display("FAIL t2_min_result: got hi=%h lo=%h want 40000000 00000000", hi_out, lo_out);
        end
        step();
        start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (hi_out !== 32'h4000_0000 || lo_out !== 32'h0) begin
            n_fail++;
            $display("FAIL t2_hold: got hi=%h lo=%h want previous 40000000 00000000", hi_out, lo_out);
        end
        wait_done(cyc, sm, sd, sz);
        n_checks++;
        if (cyc != 33 || hi_out !== 32'h0 || lo_out !== 32'h1) begin
            n_fail++;
            $display("FAIL t2_neg1_result: got cycle=%0d hi=%h lo=%h want 33 0 1", cyc, hi_out, lo_out);
        end
        step();
    endtask

    task automatic test_div();
        int   cyc;
        logic sm, sd, sz;
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, sm, sd, sz);
        n_checks++;
        if (cyc != 33 || sd !== 1'b1 || sm !== 1'b0 || sz !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_neg_done: got cycle=%0d dd=%b md=%b dz=%b want 33 1 0 0", cyc, sd, sm, sz);
        end
        n_checks++;
        if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL t3_neg_result: got lo=%h hi=%h want fffffffd ffffffff", lo_out, hi_out);
        end
        step();
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        wait_done(cyc, sm, sd, sz);
        n_checks++;
        if (cyc != 33 || lo_out !== 32'd14 || hi_out !== 32'd2) begin
            n_fail++;
            $display("FAIL t3_pos_result: got cycle=%0d lo=%0d hi=%0d want 33 14 2", cyc, lo_out, hi_out);
        end
        step();
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, sm, sd, sz);
        n_checks++;
        if (cyc != 33 || lo_out !== 32'h8000_0000 || hi_out !== 32'h0) begin
            n_fail++;
            $display("FAIL t3_overflow: got cycle=%0d lo=%h hi=%h want 33 80000000 0", cyc, lo_out, hi_out);
        end
        step();
    endtask

    task automatic test_div_by_zero();
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        n_checks++;
        if (div_done !== 1'b1 || div_by_zero !== 1'b1 || busy !== 1'b1 || mult_done !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_flags: got dd=%b dz=%b busy=%b md=%b want 1 1 1 0",
                     div_done, div_by_zero, busy, mult_done);
        end
        n_checks++;
        if (hi_out !== 32'd5 || lo_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL t4_result: got hi=%h lo=%h want 00000005 ffffffff", hi_out, lo_out);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || div_done !== 1'b0 || div_by_zero !== 1'b0 || hi_out !== 32'd5) begin
            n_fail++;
            $display("FAIL t4_after: got busy=%b dd=%b dz=%b hi=%h want 0 0 0 00000005",
                     busy, div_done, div_by_zero, hi_out);
        end
    endtask

    task automatic test_arbitration();
        int          mcyc = -1;
        int          dcnt = 0;
        logic [31:0] rhi = 32'hX;
        logic [31:0] rlo = 32'hX;
        start_op(1'b1, 1'b1, 32'd6, 32'd4);
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin
                div_start = 1'b1;
                a_in      = 32'd9;
                b_in      = 32'd0;
            end
            if (c == 11) div_start = 1'b0;
            if (mult_done && mcyc < 0) begin
                mcyc = c;
                rhi  = hi_out;
                rlo  = lo_out;
            end
            if (div_done || div_by_zero) dcnt++;
            step();
        end
        n_checks++;
        if (mcyc != 33 || dcnt != 0) begin
            n_fail++;
            $display("FAIL t5_arb: got mult_done cycle=%0d div_done count=%0d want 33 0", mcyc, dcnt);
        end
        n_checks++;
        if (rhi !== 32'h0 || rlo !== 32'd24) begin
            n_fail++;
            $display("FAIL t5_result: got hi=%h lo=%0d want 0 24", rhi, rlo);
        end
    endtask

    task automatic test_reset_abort();
        int   cyc;
        int   dcnt = 0;
        logic sm, sd, sz;
        start_op(1'b1, 1'b0, 32'd123, 32'd456);
        for (int c = 1; c < 15; c++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_checks++;
        if ({hi_out, lo_out} !== 64'h0 || {mult_done, div_done, div_by_zero, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL t6_abort: got hi=%h lo=%h md=%b dd=%b dz=%b busy=%b want all 0",
                     hi_out, lo_out, mult_done, div_done, div_by_zero, busy);
        end
        for (int c = 0; c < 40; c++) begin
            if (mult_done || div_done || busy) dcnt++;
            step();
        end
        n_checks++;
        if (dcnt != 0) begin
            n_fail++;
            $display("FAIL t6_no_done: got %0d active cycles after abort want 0", dcnt);
        end
        start_op(1'b0, 1'b1, 32'd9, 32'd3);
        wait_done(cyc, sm, sd, sz);
        n_checks++;
        if (cyc != 33 || sd !== 1'b1 || lo_out !== 32'd3 || hi_out !== 32'd0) begin
            n_fail++;
            $display("FAIL t6_restart: got cycle=%0d dd=%b lo=%0d hi=%0d want 33 1 3 0", cyc, sd, lo_out, hi_out);
        end
        step();
    endtask

    // Start held high through DONE: ignored there, accepted in the next IDLE cycle.
    task automatic test_back_to_back();
        int          first = -1;
        int          second = -1;
        int          ndone = 0;
        logic [31:0] lo1 = 32'hX;
        logic [31:0] lo2 = 32'hX;
        mult_start = 1'b1;
        a_in       = 32'd3;
        b_in       = 32'd5;
        for (int c = 1; c <= 75; c++) begin
            step();
            if (c == 20) a_in = 32'd4;
            if (c == 35) mult_start = 1'b0;
            if (mult_done) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    lo1   = lo_out;
                end else if (second < 0) begin
                    second = c;
                    lo2    = lo_out;
                end
            end
        end
        n_checks++;
        if (ndone != 2 || first != 33 || second != 67) begin
            n_fail++;
            $display("FAIL b2b_timing: got pulses=%0d at %0d,%0d want 2 at 33,67", ndone, first, second);
        end
        n_checks++;
        if (lo1 !== 32'd15 || lo2 !== 32'd20) begin
            n_fail++;
            $display("FAIL b2b_result: got lo=%0d,%0d want 15,20", lo1, lo2);
        end
    endtask

    initial begin
        test_reset();
        test_mult_timing();
        test_mult_corners();
        test_div();
        test_div_by_zero();
        test_arbitration();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
